// File: rtl/trim_pkg.sv
// Shared definitions for the serial trim link (trim_gen transmitter, trim_rx receiver).
package trim_pkg;

  localparam int                    TRIM_WIDTH      = 12;
  localparam logic [TRIM_WIDTH-1:0] TRIM_RESET_CODE = 12'h800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } trim_state_e;

  // Even parity check: true when the vector (data plus parity bit) has an even number of ones.
  function automatic logic even_parity_ok(input logic [63:0] bits);
    return ~(^bits);
  endfunction

endpackage

// File: rtl/trim_sync.sv
// STAGES-deep single-bit synchronizer with asynchronous active-low reset.
module trim_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_d;
  logic [STAGES-1:0] sync_q;

  // Next value of the chain: shift the asynchronous input in at the bottom.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/trim_rx.sv
// Receive side of the serial trim link: oversamples ENCLK/DIN on CLK50, assembles an
// MSB-first trim word, validates the frame length and holds the last good code for the DAC.
// Optional feature: define TRIM_RX_PARITY_EN to expect a trailing even-parity bit.
module trim_rx
  import trim_pkg::*;
#(
  parameter int               WIDTH        = TRIM_WIDTH,
  parameter int               SYNC_STAGES  = 2,
  parameter int               IDLE_TIMEOUT = 8,
  parameter logic [WIDTH-1:0] RESET_CODE   = TRIM_RESET_CODE
) (
  input  logic             CLK50,
  input  logic             RST,
  input  logic             ENCLK,
  input  logic             DIN,
  input  logic             LOCK,
  output logic [WIDTH-1:0] TRIM_CODE,
  output logic             CODE_VALID,
  output logic             FRAME_ERR,
  output logic             BUSY
);

`ifdef TRIM_RX_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH + 3);
  localparam int TMO_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH + 2);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IDLE_TIMEOUT - 1);

  logic enclk_s;
  logic din_s;
  logic rise;
  logic frame_good;

  logic                  enclk_dly_d, enclk_dly_q;
  trim_state_e           state_d,     state_q;
  logic [FRAME_BITS-1:0] shreg_d,     shreg_q;
  logic [CNT_W-1:0]      bitcnt_d,    bitcnt_q;
  logic [TMO_W-1:0]      tmo_d,       tmo_q;
  logic [WIDTH-1:0]      trim_code_d, trim_code_q;
  logic                  code_valid_d, code_valid_q;
  logic                  frame_err_d,  frame_err_q;

  // Equal-depth synchronizers keep ENCLK and DIN aligned relative to each other.
  trim_sync #(.STAGES(SYNC_STAGES)) u_sync_enclk (
    .clk   (CLK50),
    .rst_n (RST),
    .din   (ENCLK),
    .dout  (enclk_s)
  );

  trim_sync #(.STAGES(SYNC_STAGES)) u_sync_din (
    .clk   (CLK50),
    .rst_n (RST),
    .din   (DIN),
    .dout  (din_s)
  );

  assign rise = enclk_s & ~enclk_dly_q;

  // A frame is accepted only on an exact bit count (and correct parity when enabled).
`ifdef TRIM_RX_PARITY_EN
  assign frame_good = (bitcnt_q == CNT_W'(FRAME_BITS)) && even_parity_ok(64'(shreg_q));
`else
  assign frame_good = (bitcnt_q == CNT_W'(FRAME_BITS));
`endif

  // Frame FSM: collect bits on each rise, close on idle timeout, decide in CHECK.
  always_comb begin
    enclk_dly_d  = enclk_s;
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    tmo_d        = tmo_q;
    trim_code_d  = trim_code_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d  = SHIFT;
          shreg_d  = {shreg_q[FRAME_BITS-2:0], din_s};
          bitcnt_d = CNT_W'(1);
          tmo_d    = '0;
        end
      end
      SHIFT: begin
        if (rise) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], din_s};
          if (bitcnt_q != CNT_MAX) bitcnt_d = bitcnt_q + CNT_W'(1);
          tmo_d   = '0;
        end else if (!enclk_s) begin
          if (tmo_q == TMO_LAST) state_d = CHECK;
          else                   tmo_d   = tmo_q + TMO_W'(1);
        end
      end
      CHECK: begin
        // LOCK is looked at only here, so toggling it mid-frame is harmless.
        if (frame_good) begin
          if (!LOCK) begin
            trim_code_d  = shreg_q[FRAME_BITS-1 -: WIDTH];
            code_valid_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
        end
        state_d  = IDLE;
        shreg_d  = '0;
        bitcnt_d = '0;
        tmo_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset applies the mid-scale trim immediately.
  always_ff @(posedge CLK50 or negedge RST) begin
    if (!RST) begin
      enclk_dly_q  <= 1'b0;
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      tmo_q        <= '0;
      trim_code_q  <= RESET_CODE;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      enclk_dly_q  <= enclk_dly_d;
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      tmo_q        <= tmo_d;
      trim_code_q  <= trim_code_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign TRIM_CODE  = trim_code_q;
  assign CODE_VALID = code_valid_q;
  assign FRAME_ERR  = frame_err_q;
  assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_trim_rx.sv
// Bench for trim_rx: table of frames plus hand sequences and random frames checked
// against a frame-level model (expected outcome per frame from its length, parity and LOCK).
module tb_trim_rx;
  import trim_pkg::*;

  localparam int W  = 12;
  localparam int S  = 2;
  localparam int IT = 8;
`ifdef TRIM_RX_PARITY_EN
  localparam int FB = W + 1;
`else
  localparam int FB = W;
`endif

  logic         CLK50 = 1'b0;
  logic         RST   = 1'b1;
  logic         ENCLK = 1'b0;
  logic         DIN   = 1'b0;
  logic         LOCK  = 1'b0;
  logic [W-1:0] TRIM_CODE;
  logic         CODE_VALID;
  logic         FRAME_ERR;
  logic         BUSY;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  int last_pulse_cyc = 0;
  int last_fall = 0;
  logic [W-1:0] model_code;

  typedef struct {
    logic [W-1:0] code;
    int           delta;
    logic         lock;
    int           exp_cv;
    int           exp_fe;
    logic [W-1:0] exp_code;
  } vec_t;

  vec_t vecs[6];

  trim_rx #(
    .WIDTH        (W),
    .SYNC_STAGES  (S),
    .IDLE_TIMEOUT (IT),
    .RESET_CODE   (12'h800)
  ) dut (
    .CLK50      (CLK50),
    .RST        (RST),
    .ENCLK      (ENCLK),
    .DIN        (DIN),
    .LOCK       (LOCK),
    .TRIM_CODE  (TRIM_CODE),
    .CODE_VALID (CODE_VALID),
    .FRAME_ERR  (FRAME_ERR),
    .BUSY       (BUSY)
  );

  always #5 CLK50 = ~CLK50;

  always @(posedge CLK50) cyc <= cyc + 1;

  always @(negedge CLK50) begin
    if (CODE_VALID) begin
      cv_cnt++;
      last_pulse_cyc = cyc;
    end
    if (FRAME_ERR) begin
      fe_cnt++;
      last_pulse_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK50);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Serial bits v[n-1] .. v[0]: DIN set one cycle before the rise, held through the low phase.
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      DIN = v[i];
      tick(1);
      ENCLK = 1'b1;
      tick(3);
      ENCLK = 1'b0;
      last_fall = cyc;
      tick(3);
    end
  endtask

  function automatic logic [31:0] frame_of(input logic [W-1:0] c);
    logic [31:0] f;
    f = 32'(c);
`ifdef TRIM_RX_PARITY_EN
    f = {f[30:0], ^c};
`endif
    return f;
  endfunction

  // One whole frame with length FB+delta; waits long enough for the frame to close.
  task automatic run_frame(input string name, input logic [W-1:0] c, input int delta,
                           input logic lock, input int exp_cv, input int exp_fe,
                           input logic [W-1:0] exp_code);
    int cv0;
    int fe0;
    logic [31:0] v;
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    LOCK = lock;
    v = frame_of(c);
    if (delta >= 0) v = v << delta;
    else            v = v >> (-delta);
    send_bits(v, FB + delta);
    tick(S + IT + 8);
    chk({name, "_cv"},   32'(cv_cnt - cv0), 32'(exp_cv));
    chk({name, "_fe"},   32'(fe_cnt - fe0), 32'(exp_fe));
    chk({name, "_code"}, 32'(TRIM_CODE),    32'(exp_code));
  endtask

  initial begin
    int cv0;
    int fe0;
    logic [31:0] v;
    logic [W-1:0] c;
    int d;
    logic lk;
    int ecv;
    int efe;

    vecs[0] = '{code: 12'hA5C, delta:  0, lock: 1'b0, exp_cv: 1, exp_fe: 0, exp_code: 12'hA5C};
    vecs[1] = '{code: 12'hFFF, delta: -1, lock: 1'b0, exp_cv: 0, exp_fe: 1, exp_code: 12'hA5C};
    vecs[2] = '{code: 12'h555, delta:  1, lock: 1'b0, exp_cv: 0, exp_fe: 1, exp_code: 12'hA5C};
    vecs[3] = '{code: 12'h123, delta:  0, lock: 1'b0, exp_cv: 1, exp_fe: 0, exp_code: 12'h123};
    vecs[4] = '{code: 12'h3C3, delta:  0, lock: 1'b1, exp_cv: 0, exp_fe: 0, exp_code: 12'h123};
    vecs[5] = '{code: 12'h3C3, delta:  0, lock: 1'b0, exp_cv: 1, exp_fe: 0, exp_code: 12'h3C3};

    // Reset values, during and after reset.
    #2 RST = 1'b0;
    tick(5);
    chk("rst_code", 32'(TRIM_CODE), 32'h800);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_cv",   32'(CODE_VALID), 32'd0);
    chk("rst_fe",   32'(FRAME_ERR), 32'd0);
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    RST = 1'b1;
    tick(12);
    chk("idle_code",   32'(TRIM_CODE), 32'h800);
    chk("idle_pulses", 32'(cv_cnt - cv0 + fe_cnt - fe0), 32'd0);

    // Table of frames.
    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].code, vecs[i].delta, vecs[i].lock,
                vecs[i].exp_cv, vecs[i].exp_fe, vecs[i].exp_code);
    end
    model_code = 12'h3C3;

    // Latency from the final ENCLK fall at the pin to the result pulse.
    run_frame("lat_short", 12'hFFF, -1, 1'b0, 0, 1, model_code);
    chk("lat_short_cyc", 32'(last_pulse_cyc - last_fall), 32'(S + IT + 1));
    run_frame("lat_good", 12'h5A5, 0, 1'b0, 1, 0, 12'h5A5);
    chk("lat_good_cyc", 32'(last_pulse_cyc - last_fall), 32'(S + IT + 1));
    model_code = 12'h5A5;

    // LOCK changes mid-frame: only its value when the frame closes matters.
    cv0 = cv_cnt;
    v = frame_of(12'h0C3);
    LOCK = 1'b1;
    send_bits(v >> (FB - 6), 6);
    LOCK = 1'b0;
    send_bits(v, FB - 6);
    tick(S + IT + 8);
    chk("lock_drop_cv",   32'(cv_cnt - cv0), 32'd1);
    chk("lock_drop_code", 32'(TRIM_CODE), 32'h0C3);
    cv0 = cv_cnt;
    v = frame_of(12'hF0F);
    LOCK = 1'b0;
    send_bits(v >> (FB - 6), 6);
    LOCK = 1'b1;
    send_bits(v, FB - 6);
    tick(S + IT + 8);
    chk("lock_set_cv",   32'(cv_cnt - cv0), 32'd0);
    chk("lock_set_code", 32'(TRIM_CODE), 32'h0C3);
    LOCK = 1'b0;

    // Reset in the middle of a frame, then a clean frame.
    v = frame_of(12'hABC);
    send_bits(v >> (FB - 6), 6);
    chk("mid_busy", 32'(BUSY), 32'd1);
    RST = 1'b0;
    #1;
    chk("mid_rst_code", 32'(TRIM_CODE), 32'h800);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    tick(3);
    RST = 1'b1;
    tick(3);
    run_frame("after_rst", 12'h0F0, 0, 1'b0, 1, 0, 12'h0F0);
    model_code = 12'h0F0;

`ifdef TRIM_RX_PARITY_EN
    // Wrong parity bit must be rejected.
    fe0 = fe_cnt;
    cv0 = cv_cnt;
    send_bits({19'b0, 12'h777, ~(^12'h777)}, FB);
    tick(S + IT + 8);
    chk("bad_par_fe",   32'(fe_cnt - fe0), 32'd1);
    chk("bad_par_cv",   32'(cv_cnt - cv0), 32'd0);
    chk("bad_par_code", 32'(TRIM_CODE), 32'(model_code));
`endif

    // Random frames against the frame-level model.
    for (int k = 0; k < 24; k++) begin
      c  = W'($urandom);
      d  = ($urandom_range(0, 2) == 0) ? (int'($urandom_range(0, 4)) - 2) : 0;
      lk = ($urandom_range(0, 3) == 0);
      if (d != 0) begin
        ecv = 0;
        efe = 1;
      end else if (lk) begin
        ecv = 0;
        efe = 0;
      end else begin
        ecv = 1;
        efe = 0;
        model_code = c;
      end
      run_frame($sformatf("rnd%0d", k), c, d, lk, ecv, efe, model_code);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
